alu_arbiter: RTL



---
 rtl/alu_ctrl_pkg.sv | 28 ++
 rtl/alu_arbiter_rr_arb2.sv | 25 ++
 rtl/alu_arbiter.sv | 121 ++++++++++++
 3 files changed

// File: rtl/alu_ctrl_pkg.sv
// alu_ctrl_pkg: shared types and constants for the ALU arbiter slice
package alu_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        ARM   = 3'd2,
        WAIT  = 3'd3,
        RESP  = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        SEL_ILLEGAL = 2'b00,
        SEL_A       = 2'b01,
        SEL_B1      = 2'b10,
        SEL_B2      = 2'b11
    } sel_t;

    typedef struct packed {
        logic [4:0] a;
        logic [4:0] b;
        sel_t       sel;
        logic [2:0] op;
    } req_t;

    localparam int RESULT_LAT_DEF = 2;

endpackage

// File: rtl/alu_arbiter_rr_arb2.sv
// rr_arb2: two-requester round-robin grant; last_grant resets to 1 so requester 0 wins the first tie
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] valid,
    input  logic       en,
    input  logic       accept,
    output logic [1:0] grant,
    output logic       grant_id
);

    logic last_grant;

    assign grant_id = (valid == 2'b11) ? ~last_grant : valid[1];
    assign grant    = en ? (valid & (grant_id ? 2'b10 : 2'b01)) : 2'b00;

    // remember the most recently accepted requester for tie-breaking
    always_ff @(posedge clk) begin
        if (!rst_n)
            last_grant <= 1'b1;
        else if (accept)
            last_grant <= grant_id;
    end

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one sign-magnitude ALU between two requesters; optional grant counters via ALU_ARB_STATS_EN
module alu_arbiter
    import alu_ctrl_pkg::*;
#(
    parameter int RESULT_LAT = RESULT_LAT_DEF,
    parameter int CNT_W      = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [1:0]      req_valid,
    output logic [1:0]      req_ready,
    input  logic [1:0][4:0] req_a,
    input  logic [1:0][4:0] req_b,
    input  logic [1:0][1:0] req_sel,
    input  logic [1:0][2:0] req_op,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic            rsp_id,
    output logic [5:0]      rsp_data,
    output logic            rsp_err,
    output logic            alu_en,
    output logic            alu_a_en,
    output logic            alu_b_en,
    output logic [4:0]      alu_a,
    output logic [4:0]      alu_b,
    output logic [2:0]      alu_a_op,
    output logic [1:0]      alu_b_op,
    input  logic [5:0]      alu_c
`ifdef ALU_ARB_STATS_EN
    ,
    output logic [CNT_W-1:0] grant_cnt0,
    output logic [CNT_W-1:0] grant_cnt1
`endif
);

    state_t     state;
    req_t       cur;
    logic       id_q;
    logic       err_q;
    logic [5:0] data_q;
    logic [2:0] wcnt;
    logic       gid;
    logic       accept;
    logic       live;
    logic       arm;

    rr_arb2 u_arb (
        .clk      (clk),
        .rst_n    (rst_n),
        .valid    (req_valid),
        .en       (rst_n && state == IDLE),
        .accept   (accept),
        .grant    (req_ready),
        .grant_id (gid)
    );

    assign accept = |(req_valid & req_ready);

    // request sequencing: latch on accept, pulse alu_en, arm the op, wait for the result, hold the response
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            cur    <= '0;
            id_q   <= 1'b0;
            err_q  <= 1'b0;
            data_q <= '0;
            wcnt   <= '0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    cur    <= '{a: req_a[gid], b: req_b[gid], sel: sel_t'(req_sel[gid]), op: req_op[gid]};
                    id_q   <= gid;
                    err_q  <= (req_sel[gid] == SEL_ILLEGAL);
                    data_q <= '0;
                    state  <= (req_sel[gid] == SEL_ILLEGAL) ? RESP : ISSUE;
                end
                ISSUE: state <= ARM;
                ARM: begin
                    wcnt  <= 3'(RESULT_LAT - 1);
                    state <= WAIT;
                end
                WAIT: if (wcnt == 3'd0) begin
                    data_q <= alu_c;
                    state  <= RESP;
                end else begin
                    wcnt <= wcnt - 3'd1;
                end
                RESP: if (rsp_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign live      = state inside {ISSUE, ARM, WAIT};
    assign arm       = (state == ARM);
    assign alu_en    = (state == ISSUE);
    assign alu_a     = live ? cur.a : '0;
    assign alu_b     = live ? cur.b : '0;
    assign alu_a_en  = arm && cur.sel inside {SEL_A, SEL_B2};
    assign alu_b_en  = arm && cur.sel inside {SEL_B1, SEL_B2};
    assign alu_a_op  = (arm && cur.sel == SEL_A) ? cur.op : '0;
    assign alu_b_op  = (arm && cur.sel inside {SEL_B1, SEL_B2}) ? cur.op[1:0] : '0;
    assign rsp_valid = (state == RESP);
    assign rsp_id    = rsp_valid & id_q;
    assign rsp_err   = rsp_valid & err_q;
    assign rsp_data  = rsp_valid ? data_q : '0;

`ifdef ALU_ARB_STATS_EN
    // saturating per-requester grant counters
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            grant_cnt0 <= '0;
            grant_cnt1 <= '0;
        end else if (accept) begin
            if (!gid && !(&grant_cnt0)) grant_cnt0 <= grant_cnt0 + CNT_W'(1);
            if (gid && !(&grant_cnt1)) grant_cnt1 <= grant_cnt1 + CNT_W'(1);
        end
    end
`endif

endmodule
